// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment bit
// positions inside the {a,b,c,d,e,f,g} vector and the hex glyph table.
package seg_pkg;

    // Bit positions of each segment in the 7-bit segment vector.
    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    // Hex glyphs 0-F; 'b' and 'd' use the lower-case forms so they differ from 8 and 0.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'b111_1110, 7'b011_0000, 7'b110_1101, 7'b111_1001,
        7'b011_0011, 7'b101_1011, 7'b101_1111, 7'b111_0000,
        7'b111_1111, 7'b111_1011, 7'b111_0111, 7'b001_1111,
        7'b100_1110, 7'b011_1101, 7'b100_1111, 7'b100_0111
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to seven-segment decoder.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Look up the glyph for the selected nibble.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment display scan controller with shadow/display
// double buffering, frame-synchronous commit and PWM brightness.
// Optional build macro SEG_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int PS_W    = 16,
    parameter int DUTY_W  = 3
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NDIGITS-1:0]   data,
    input  logic                   load,
    input  logic [NDIGITS-1:0]     dp,
    input  logic [DUTY_W-1:0]      bright,
    output logic [NDIGITS-1:0]     anodes,
    output logic [6:0]             segments,
    output logic                   dp_out,
    output logic                   pending,
    output logic                   frame_tick
);

    localparam int                 IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NDIGITS - 1);
    localparam logic [PS_W-1:0]    CNT_MAX  = {PS_W{1'b1}};
    localparam logic [PS_W-1:0]    CNT_ZERO = {PS_W{1'b0}};
    localparam logic [DUTY_W-1:0]  DUTY_MAX = {DUTY_W{1'b1}};

    logic [PS_W-1:0]       cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [DUTY_W-1:0]     bright_hold_r;
    logic [4*NDIGITS-1:0]  shadow_r;
    logic [NDIGITS-1:0]    shadow_dp_r;
    logic [4*NDIGITS-1:0]  disp_r;
    logic [NDIGITS-1:0]    disp_dp_r;
    logic                  pending_r;
    logic [NDIGITS-1:0]    anodes_r;
    logic [6:0]            segments_r;
    logic                  dp_out_r;
    logic                  frame_tick_r;

    logic                  slot_end_s;
    logic                  commit_s;
    logic [DUTY_W-1:0]     bright_eff_s;
    logic                  anode_on_s;
    logic [NDIGITS-1:0]    digit_sel_s;
    logic [3:0]            cur_nib_s;
    logic                  cur_dp_s;
    logic [6:0]            glyph_s;
    logic                  blank_s;
    logic [6:0]            seg_shown_s;

    // Slot/frame boundaries and the brightness level that applies to this cycle.
    always_comb begin
        slot_end_s = (cnt_r == CNT_MAX);
        commit_s   = slot_end_s && (idx_r == LAST_IDX);
        // At slot start the register has not captured yet, so use the live input.
        if (cnt_r == CNT_ZERO) begin
            bright_eff_s = bright;
        end else begin
            bright_eff_s = bright_hold_r;
        end
        if (bright_eff_s == DUTY_MAX) begin
            anode_on_s = 1'b1;
        end else begin
            anode_on_s = (cnt_r[PS_W-1 -: DUTY_W] < bright_eff_s);
        end
    end

    // Select the current digit's nibble, decimal point and one-hot anode.
    always_comb begin
        digit_sel_s = {NDIGITS{1'b0}};
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            digit_sel_s[i] = (idx_r == IDX_W'(i));
            cur_nib_s      = cur_nib_s | (digit_sel_s[i] ? disp_r[4*i +: 4] : 4'h0);
            cur_dp_s       = cur_dp_s  | (digit_sel_s[i] & disp_dp_r[i]);
        end
    end

    seg_decode u_seg_decode (
        .nibble (cur_nib_s),
        .seg    (glyph_s)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic [NDIGITS-1:0] zero_from_s;

    // Blank a digit above 0 when it and every higher nibble are zero.
    always_comb begin
        logic acc_v;
        acc_v       = 1'b1;
        zero_from_s = {NDIGITS{1'b0}};
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            acc_v          = acc_v & (disp_r[4*i +: 4] == 4'h0);
            zero_from_s[i] = acc_v;
        end
        blank_s = (idx_r != {IDX_W{1'b0}}) && ((zero_from_s & digit_sel_s) != {NDIGITS{1'b0}});
    end
`else
    // Every digit always shows its glyph in this build.
    always_comb begin
        blank_s = 1'b0;
    end
`endif

    // Final segment pattern, honouring blanking.
    always_comb begin
        if (blank_s) begin
            seg_shown_s = SEG_OFF;
        end else begin
            seg_shown_s = glyph_s;
        end
    end

    // Prescaler, digit index and per-slot brightness capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r         <= CNT_ZERO;
            idx_r         <= {IDX_W{1'b0}};
            bright_hold_r <= {DUTY_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + PS_W'(1'b1);
            if (cnt_r == CNT_ZERO) begin
                bright_hold_r <= bright;
            end
            if (slot_end_s) begin
                idx_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1'b1));
            end
        end
    end

    // Shadow capture and frame-synchronous commit into the display register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_r    <= {(4*NDIGITS){1'b0}};
            shadow_dp_r <= {NDIGITS{1'b0}};
            disp_r      <= {(4*NDIGITS){1'b0}};
            disp_dp_r   <= {NDIGITS{1'b0}};
            pending_r   <= 1'b0;
        end else begin
            if (load) begin
                shadow_r    <= data;
                shadow_dp_r <= dp;
            end
            if (commit_s) begin
                // A load on the commit cycle goes straight to the display.
                disp_r    <= load ? data : shadow_r;
                disp_dp_r <= load ? dp   : shadow_dp_r;
                pending_r <= 1'b0;
            end else if (load) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anodes_r     <= {NDIGITS{1'b0}};
            segments_r   <= SEG_OFF;
            dp_out_r     <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            anodes_r     <= anode_on_s ? digit_sel_s : {NDIGITS{1'b0}};
            segments_r   <= seg_shown_s;
            dp_out_r     <= cur_dp_s;
            frame_tick_r <= commit_s;
        end
    end

    assign anodes     = anodes_r;
    assign segments   = segments_r;
    assign dp_out     = dp_out_r;
    assign pending    = pending_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIGITS=4, PS_W=4, DUTY_W=2).
module tb_seg_scan_ctrl;

    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };
`ifdef SEG_SCAN_LZ_BLANK_EN
    localparam logic [6:0] BLANKED = 7'b000_0000;
`else
    localparam logic [6:0] BLANKED = 7'b111_1110;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  dp = 4'h0;
    logic [1:0]  bright = 2'd3;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic        dp_out;
    logic        pending;
    logic        frame_tick;

    int n_vec = 0;
    int n_err = 0;
    int ncyc  = 0;

    seg_scan_ctrl #(.NDIGITS(4), .PS_W(4), .DUTY_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .load       (load),
        .dp         (dp),
        .bright     (bright),
        .anodes     (anodes),
        .segments   (segments),
        .dp_out     (dp_out),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: time t counts cycles since reset release; cnt, digit and
    // frame position follow from plain arithmetic on t.
    int          m_t = 0;
    logic [15:0] m_disp = 16'h0, m_shadow = 16'h0;
    logic [3:0]  m_ddp = 4'h0, m_sdp = 4'h0;
    logic        m_pend = 1'b0;
    logic [1:0]  m_bs = 2'd0;
    logic [3:0]  e_an = 4'h0;
    logic [6:0]  e_seg = 7'h0;
    logic        e_dp = 1'b0, e_ft = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_t = 0; m_disp = 16'h0; m_shadow = 16'h0; m_ddp = 4'h0; m_sdp = 4'h0;
                m_pend = 1'b0; m_bs = 2'd0; e_an = 4'h0; e_seg = 7'h0; e_dp = 1'b0; e_ft = 1'b0;
            end else begin
                int cnt, idx;
                logic [15:0] upper;
                cnt = m_t % 16;
                idx = (m_t / 16) % 4;
                if (cnt == 0) m_bs = bright;
                e_an  = ((m_bs == 2'd3) || ((cnt / 4) < int'(m_bs))) ? (4'b0001 << idx) : 4'b0000;
                upper = m_disp >> (4 * idx);
                e_seg = GLYPH[upper[3:0]];
`ifdef SEG_SCAN_LZ_BLANK_EN
                if (idx > 0 && upper == 16'h0) e_seg = 7'h00;
`endif
                e_dp = m_ddp[idx];
                e_ft = (cnt == 15) && (idx == 3);
                if (e_ft) begin
                    m_disp = load ? data : m_shadow;
                    m_ddp  = load ? dp : m_sdp;
                    m_pend = 1'b0;
                end else if (load) begin
                    m_pend = 1'b1;
                end
                if (load) begin
                    m_shadow = data;
                    m_sdp    = dp;
                end
                m_t++;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("anodes", 32'(anodes), 32'(e_an));
            chk("segments", 32'(segments), 32'(e_seg));
            chk("dp_out", 32'(dp_out), 32'(e_dp));
            chk("frame_tick", 32'(frame_tick), 32'(e_ft));
            chk("pending", 32'(pending), 32'(m_pend));
        end
    end

    task automatic tick();
        @(negedge clk);
        ncyc++;
    endtask

    task automatic goto(input int n);
        while (ncyc < n) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        data = d; dp = p; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic count_on(input string name, input int exp);
        int c;
        c = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (anodes != 4'h0) c++;
        end
        chk(name, 32'(c), 32'(exp));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_anodes", 32'(anodes), 32'h0);
        chk("rst_segments", 32'(segments), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        rst = 1'b0; ncyc = 0;

        tick();
        chk("first_seg", 32'(segments), 32'h7E);
        chk("first_an", 32'(anodes), 32'h1);
        do_load(16'hC1AC, 4'b0010);
        chk("load_pending", 32'(pending), 32'h1);
        goto(64);
        chk("commit_ft", 32'(frame_tick), 32'h1);
        chk("commit_pend", 32'(pending), 32'h0);
        goto(65);  chk("d0_seg", 32'(segments), 32'h4E); chk("d0_an", 32'(anodes), 32'h1);
        goto(81);  chk("d1_seg", 32'(segments), 32'h77); chk("d1_an", 32'(anodes), 32'h2);
        chk("d1_dp", 32'(dp_out), 32'h1);
        goto(97);  chk("d2_seg", 32'(segments), 32'h30); chk("d2_an", 32'(anodes), 32'h4);
        goto(113); chk("d3_seg", 32'(segments), 32'h4E); chk("d3_an", 32'(anodes), 32'h8);

        goto(120); bright = 2'd1;
        goto(128); count_on("duty_b1", 4);
        bright = 2'd0; count_on("duty_b0", 0);
        bright = 2'd3; count_on("duty_b3", 16);

        goto(210); do_load(16'h1234, 4'b0001);
        chk("mid_pending", 32'(pending), 32'h1);
        tick(); chk("no_tear", 32'(segments), 32'h77);
        goto(256); chk("ft2", 32'(frame_tick), 32'h1); chk("pend2", 32'(pending), 32'h0);
        goto(257); chk("show4", 32'(segments), 32'h33); chk("dp4", 32'(dp_out), 32'h1);

        goto(319); do_load(16'hABCD, 4'b0000);
        chk("bypass_pend", 32'(pending), 32'h0);
        chk("bypass_ft", 32'(frame_tick), 32'h1);
        tick(); chk("bypass_seg", 32'(segments), 32'h3D);

        goto(330); do_load(16'h1111, 4'b0000);
        goto(335); do_load(16'h2222, 4'b0000);
        chk("lastwin_pend", 32'(pending), 32'h1);
        goto(385); chk("lastwin_seg", 32'(segments), 32'h6D);

        goto(400); do_load(16'h7777, 4'b1111);
        chk("pre_rst_pend", 32'(pending), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_an", 32'(anodes), 32'h0);
        chk("async_seg", 32'(segments), 32'h0);
        chk("async_pend", 32'(pending), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0; ncyc = 0;
        tick(); chk("rel_seg", 32'(segments), 32'h7E); chk("rel_dp", 32'(dp_out), 32'h0);
        goto(17); chk("rel_d1", 32'(segments), 32'(BLANKED));

        do_load(16'h0042, 4'b0000);
        goto(65);  chk("lz_d0", 32'(segments), 32'h6D);
        goto(81);  chk("lz_d1", 32'(segments), 32'h33);
        goto(97);  chk("lz_d2", 32'(segments), 32'(BLANKED));
        goto(113); chk("lz_d3", 32'(segments), 32'(BLANKED));
        goto(114); do_load(16'h0000, 4'b0000);
        goto(129); chk("z_d0", 32'(segments), 32'h7E);
        goto(145); chk("z_d1", 32'(segments), 32'(BLANKED));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NDIGITS, default 4, digit count, legal range 1..8.
REQ-002 Parameter PS_W, default 16, log2 of clk cycles per digit slot; SHALL be >= DUTY_W.
REQ-003 Parameter DUTY_W, default 3, brightness resolution in bits.
REQ-004 Port clk  in  1  single clock, all state on rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port data  in  4*NDIGITS  hex nibbles; nibble i (data[4i+3:4i]) drives digit i.
REQ-007 Port load  in  1  one-cycle strobe; captures data and dp into shadow.
REQ-008 Port dp  in  NDIGITS  decimal-point request per digit.
REQ-009 Port bright  in  DUTY_W  brightness level.
REQ-010 Port anodes  out  NDIGITS  active-high digit enable; at most one bit set.
REQ-011 Port segments  out  7  active-high {a,b,c,d,e,f,g}.
REQ-012 Port dp_out  out  1  active-high decimal point of the current digit.
REQ-013 Port pending  out  1  shadow holds data not yet shown.
REQ-014 Port frame_tick  out  1  one-cycle pulse at every frame commit point.

Function
REQ-015 Prescaler cnt (PS_W bits) increments every cycle and wraps; slot ends when cnt == all-ones.
REQ-016 Digit index advances 0,1,..,NDIGITS-1,0 at slot end; one frame = NDIGITS slots.
REQ-017 Commit point = slot end with index NDIGITS-1; frame_tick high that cycle.
REQ-018 At commit, shadow copies to display register; pending clears.
REQ-019 load sets shadow and pending the next cycle; a load while pending overwrites (last wins).
REQ-020 load coincident with commit: new data bypasses straight into display register; pending = 0.
REQ-021 Display register changes only at commit; no tearing within a frame.
REQ-022 bright sampled at slot start and held for the slot.
REQ-023 Anode on while cnt[PS_W-1 -: DUTY_W] < bright_sampled; bright == all-ones forces on for whole slot; bright == 0 keeps anode off.
REQ-024 segments = hex-to-7seg of current nibble (0-9, A-F standard glyphs, b and d lower-case).
REQ-025 All outputs registered; anodes/segments/dp_out reflect cnt/index state with exactly 1-cycle latency.
REQ-026 segments and dp_out reflect the current digit for the whole slot, including while the anode is off.

Reset
REQ-027 On rst: cnt, index, shadow, display register, pending, frame_tick, anodes, segments, dp_out = 0, effective immediately.
REQ-028 First slot after release is digit 0 showing display register 0 (glyph "0"), bright sampled at first slot start.
REQ-029 rst mid-slot or mid-frame discards the shadow; no partial commit.

Configuration
REQ-030 Macro SEG_SCAN_LZ_BLANK_EN defined: digit i > 0 blanked (segments = 0) when nibbles i..NDIGITS-1 are all zero; digit 0 never blanked; dp_out unaffected.
REQ-031 Macro undefined: no blanking; every digit shows its glyph.

Structure
REQ-032 Package seg_pkg holds the 16-entry glyph table and segment-bit index constants.
REQ-033 Combinational sub-module seg_decode (nibble -> 7 segments) instantiated once on the muxed nibble.

Verification (NDIGITS=4, PS_W=4, DUTY_W=2)
REQ-034 Reset, bright=3, load data=16'hC1AC -> after next commit, slots 0..3 segments 1001110, 1110111, 0110000, 1001110; anodes 0001,0010,0100,1000.
REQ-035 bright=1 -> anode high 4 of 16 cycles per slot; bright=0 -> anodes stay 0; bright=3 -> 16 of 16.
REQ-036 load 16'h1234 in slot 1 -> pending=1, segments unchanged until commit; frame_tick and pending=0 at slot-3 end; slot 0 then shows '4' = 0110011.
REQ-037 With SEG_SCAN_LZ_BLANK_EN, data=16'h0042 -> digits 3,2 segments 0000000, digit 1 0110011, digit 0 1101101; data=0 -> only digit 0 shows 1111110.
REQ-038 rst asserted mid-slot with pending=1 -> anodes, segments, pending 0 same cycle; after release, display shows 0000.
